// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate strobe, position counters, registered syncs.
// Optional VGA_FRAME_CNT_EN adds an 8-bit frame_count output for the colour stage.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       x_next;
  logic [9:0]       y_next;

  // Gated by reset so a divide-by-one build does not strobe while held in reset.
  assign pix_tick = ~reset & (div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb begin
    x_next = pix_x;
    y_next = pix_y;
    if (pix_tick) begin
      if (pix_x == H_LAST) begin
        x_next = 10'd0;
        y_next = (pix_y == V_LAST) ? 10'd0 : pix_y + 10'd1;
      end else begin
        x_next = pix_x + 10'd1;
      end
    end
  end

  // Syncs and blanking are decoded from the next position so they line up with the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_x       <= H_LAST;
      pix_y       <= V_LAST;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_x       <= x_next;
      pix_y       <= y_next;
      hsync_n     <= ~((x_next >= HS_START) && (x_next < HS_END));
      vsync_n     <= ~((y_next >= VS_START) && (y_next < VS_END));
      video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
      frame_start <= pix_tick && (x_next == 10'd0) && (y_next == 10'd0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= 8'd0;
    end else if (frame_start) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized reset/run bench for vga_sync_gen against a closed-form timing model.
// Two small-geometry instances (divide-by-2 and divide-by-1) keep whole frames short.
module tb_vga_sync_gen;

  localparam int A_CD = 2, A_HV = 8, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int A_VV = 4, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int B_CD = 1, B_HV = 6, B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;

  typedef struct {
    bit tick;
    int x;
    int y;
    bit hs_n;
    bit vs_n;
    bit von;
    bit fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_tick, a_hsync_n, a_vsync_n, a_video_on, a_frame_start;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_hsync_n, b_vsync_n, b_video_on, b_frame_start;
  logic [9:0] b_x, b_y;

  int assertCount = 0;
  int failCount   = 0;
  int k           = 0;

  always #10 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(A_CD), .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_tick(a_tick), .pix_x(a_x), .pix_y(a_y),
    .hsync_n(a_hsync_n), .vsync_n(a_vsync_n), .video_on(a_video_on),
    .frame_start(a_frame_start)
  );

  vga_sync_gen #(
    .CLK_DIV(B_CD), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_tick(b_tick), .pix_x(b_x), .pix_y(b_y),
    .hsync_n(b_hsync_n), .vsync_n(b_vsync_n), .video_on(b_video_on),
    .frame_start(b_frame_start)
  );

  // Position after kk clock edges since reset release: one pixel per cd clocks,
  // starting from the last pixel of the frame.
  function automatic exp_t model(input int cd, input int hv, input int hf, input int hs,
                                 input int hb, input int vv, input int vf, input int vs,
                                 input int vb, input int kk, input bit inRst);
    exp_t e;
    int ht, vt, n, p;
    ht     = hv + hf + hs + hb;
    vt     = vv + vf + vs + vb;
    n      = ht * vt;
    p      = (n - 1 + kk / cd) % n;
    e.x    = p % ht;
    e.y    = p / ht;
    e.tick = !inRst && ((kk % cd) == cd - 1);
    e.hs_n = !((e.x >= hv + hf) && (e.x < hv + hf + hs));
    e.vs_n = !((e.y >= vv + vf) && (e.y < vv + vf + vs));
    e.von  = (e.x < hv) && (e.y < vv);
    e.fs   = (kk > 0) && (p == 0) && ((kk % cd) == 0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic checkDuts(input bit inRst);
    exp_t ea, eb;
    ea = model(A_CD, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, k, inRst);
    eb = model(B_CD, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, k, inRst);
    checkOutput("A.pix_tick", 32'(a_tick), 32'(ea.tick));
    checkOutput("A.pix_x", 32'(a_x), ea.x);
    checkOutput("A.pix_y", 32'(a_y), ea.y);
    checkOutput("A.hsync_n", 32'(a_hsync_n), 32'(ea.hs_n));
    checkOutput("A.vsync_n", 32'(a_vsync_n), 32'(ea.vs_n));
    checkOutput("A.video_on", 32'(a_video_on), 32'(ea.von));
    checkOutput("A.frame_start", 32'(a_frame_start), 32'(ea.fs));
    checkOutput("B.pix_tick", 32'(b_tick), 32'(eb.tick));
    checkOutput("B.pix_x", 32'(b_x), eb.x);
    checkOutput("B.pix_y", 32'(b_y), eb.y);
    checkOutput("B.hsync_n", 32'(b_hsync_n), 32'(eb.hs_n));
    checkOutput("B.vsync_n", 32'(b_vsync_n), 32'(eb.vs_n));
    checkOutput("B.video_on", 32'(b_video_on), 32'(eb.von));
    checkOutput("B.frame_start", 32'(b_frame_start), 32'(eb.fs));
  endtask

  task automatic stepClock();
    @(posedge clk);
    if (!reset) k++;
    @(negedge clk);
    checkDuts(reset);
  endtask

  // Called on a falling edge; drives reset and then runs and checks the given cycles.
  task automatic applyStimulus(input bit rst, input int cycles);
    reset = rst;
    if (rst) k = 0;
    repeat (cycles) stepClock();
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic asyncReset();
    #3;
    reset = 1'b1;
    k = 0;
    #1;
    checkDuts(1'b1);
    @(negedge clk);
  endtask

  function automatic bit modelHsyncA(input int kk);
    exp_t e;
    e = model(A_CD, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, kk, 1'b0);
    return e.hs_n;
  endfunction

  initial begin
    #2;
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 500);

    for (int i = 0; i < 100 && modelHsyncA(k); i++) stepClock();
    checkOutput("A.hsync_low_reached", 32'(a_hsync_n), 32'd0);
    asyncReset();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 300);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, $urandom_range(5, 400));
      if ($urandom_range(0, 1) == 1) asyncReset();
      applyStimulus(1'b1, $urandom_range(1, 4));
    end
    applyStimulus(1'b0, 600);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
